// File: rtl/cafu_nvme_responder.sv
// CAFU-side responder for one read/write request channel: accepts a request,
// holds it for a programmable service delay, then executes it against a local line store.
module cafu_nvme_responder #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          afu_clk,
   input  logic          afu_rstn,
   input  logic          i_end_proc,
   input  logic [63:0]   i_delay_cnt,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [63:0]   rd_araddr,
   output logic          rd_return_valid,
   input  logic          rd_return_ready,
   output logic [511:0]  rd_rdata,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [63:0]   wr_awaddr,
   input  logic [511:0]  wr_wdata,
   input  logic [63:0]   wr_wstrb,
   output logic          wr_return_valid,
   input  logic          wr_return_ready,
   output logic [31:0]   o_rd_cnt,
   output logic [31:0]   o_wr_cnt,
   output logic          o_addr_err
);

   // state  | meaning
   // IDLE   | waiting for a request; readies may assert
   // DELAY  | holding the request for D+1 cycles; op executes in the last one
   // RESP_R | read data presented, waiting for rd_return_ready
   // RESP_W | write completion presented, waiting for wr_return_ready
   typedef enum logic [1:0] {IDLE, DELAY, RESP_R, RESP_W} state_t;

   localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 6;

   state_t          state;
   logic            last_grant_wr;
   logic            op_wr;
   logic            op_oor;
   logic [AW-1:0]   line_idx;
   logic [511:0]    wdata_q;
   logic [63:0]     wstrb_q;
   logic [63:0]     delay_q;
   logic [63:0]     delay_cnt;
   logic [511:0]    mem [DEPTH];

   logic            accept_ok;
   logic [63:0]     req_addr;
   logic            req_oor;
   logic            exec;

   always_comb begin
      accept_ok = afu_rstn && (state == IDLE) && !i_end_proc;
      rd_ready  = accept_ok && rd_valid && (!wr_valid || last_grant_wr);
      wr_ready  = accept_ok && wr_valid && (!rd_valid || !last_grant_wr);
      req_addr  = rd_ready ? rd_araddr : wr_awaddr;
      req_oor   = (req_addr >= ADDR_LIMIT);
      exec      = (state == DELAY) && (delay_cnt == delay_q);
   end

   // Store has no reset; a write landing in the final DELAY cycle commits even under abort.
   always_ff @(posedge afu_clk) begin
      if (exec && op_wr && !op_oor) begin
         for (int b = 0; b < 64; b++) begin
            if (wstrb_q[b]) mem[line_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge afu_clk or negedge afu_rstn) begin
      if (!afu_rstn) begin
         state           <= IDLE;
         last_grant_wr   <= 1'b1;
         op_wr           <= 1'b0;
         op_oor          <= 1'b0;
         line_idx        <= '0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
         delay_q         <= '0;
         delay_cnt       <= '0;
         rd_return_valid <= 1'b0;
         wr_return_valid <= 1'b0;
         rd_rdata        <= '0;
         o_rd_cnt        <= '0;
         o_wr_cnt        <= '0;
         o_addr_err      <= 1'b0;
      end else if (i_end_proc) begin
         state           <= IDLE;
         rd_return_valid <= 1'b0;
         wr_return_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_ready || wr_ready) begin
                  op_wr         <= wr_ready;
                  last_grant_wr <= wr_ready;
                  op_oor        <= req_oor;
                  line_idx      <= req_addr[6+AW-1:6];
                  wdata_q       <= wr_wdata;
                  wstrb_q       <= wr_wstrb;
                  delay_q       <= i_delay_cnt;
                  delay_cnt     <= '0;
                  if (req_oor) o_addr_err <= 1'b1;
                  state         <= DELAY;
               end
            end
            DELAY: begin
               if (exec) begin
                  if (!op_wr) rd_rdata <= op_oor ? '0 : mem[line_idx];
                  rd_return_valid <= !op_wr;
                  wr_return_valid <= op_wr;
                  state           <= op_wr ? RESP_W : RESP_R;
               end else begin
                  delay_cnt <= delay_cnt + 64'd1;
               end
            end
            RESP_R: begin
               if (rd_return_ready) begin
                  rd_return_valid <= 1'b0;
                  o_rd_cnt        <= o_rd_cnt + 32'd1;
                  state           <= IDLE;
               end
            end
            RESP_W: begin
               if (wr_return_ready) begin
                  wr_return_valid <= 1'b0;
                  o_wr_cnt        <= o_wr_cnt + 32'd1;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cafu_nvme_responder.sv
// Bench for cafu_nvme_responder: a cycle-timed transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cafu_nvme_responder;

   localparam logic [63:0] LIMIT = 64'd1024 * 64;

   logic          afu_clk = 1'b0;
   logic          afu_rstn = 1'b0;
   logic          i_end_proc = 1'b0;
   logic [63:0]   i_delay_cnt = '0;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [63:0]   rd_araddr = '0;
   logic          rd_return_valid;
   logic          rd_return_ready = 1'b0;
   logic [511:0]  rd_rdata;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [63:0]   wr_awaddr = '0;
   logic [511:0]  wr_wdata = '0;
   logic [63:0]   wr_wstrb = '0;
   logic          wr_return_valid;
   logic          wr_return_ready = 1'b0;
   logic [31:0]   o_rd_cnt;
   logic [31:0]   o_wr_cnt;
   logic          o_addr_err;

   cafu_nvme_responder dut (
      .afu_clk(afu_clk), .afu_rstn(afu_rstn), .i_end_proc(i_end_proc),
      .i_delay_cnt(i_delay_cnt),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_araddr(rd_araddr),
      .rd_return_valid(rd_return_valid), .rd_return_ready(rd_return_ready),
      .rd_rdata(rd_rdata),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_awaddr(wr_awaddr),
      .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
      .wr_return_valid(wr_return_valid), .wr_return_ready(wr_return_ready),
      .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt), .o_addr_err(o_addr_err)
   );

   always #5 afu_clk = ~afu_clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired without the expected event", name);
   endtask

   // Transaction-level model: one outstanding request with absolute commit/response cycles.
   logic [511:0]      mem_m [1024];
   longint unsigned   cyc = 0;
   bit                chk_en = 0;
   bit                m_busy, m_op_wr, m_last_wr, m_err;
   logic [63:0]       m_addr, m_wstrb;
   logic [511:0]      m_wdata, m_rdata;
   longint unsigned   m_commit_c, m_resp_c;
   logic [31:0]       m_rd_cnt, m_wr_cnt;

   task automatic model_reset();
      m_busy = 0; m_last_wr = 1; m_err = 0;
      m_rdata = '0; m_rd_cnt = '0; m_wr_cnt = '0;
   endtask

   task automatic model_commit(input bit aborted);
      int idx;
      idx = int'(m_addr >> 6);
      if (m_op_wr) begin
         if (m_addr < LIMIT)
            for (int b = 0; b < 64; b++)
               if (m_wstrb[b]) mem_m[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end else if (!aborted) begin
         m_rdata = (m_addr < LIMIT) ? mem_m[idx] : '0;
      end
   endtask

   always @(negedge afu_clk) begin
      if (chk_en) begin : compare
         bit e_rr, e_wr, e_rv, e_wv;
         e_rr = !m_busy && !i_end_proc && rd_valid && (!wr_valid || m_last_wr);
         e_wr = !m_busy && !i_end_proc && wr_valid && (!rd_valid || !m_last_wr);
         e_rv = m_busy && !m_op_wr && (cyc >= m_resp_c);
         e_wv = m_busy && m_op_wr && (cyc >= m_resp_c);
         chk("rd_ready", rd_ready, e_rr);
         chk("wr_ready", wr_ready, e_wr);
         chk("rd_return_valid", rd_return_valid, e_rv);
         chk("wr_return_valid", wr_return_valid, e_wv);
         chk("rd_rdata", rd_rdata, m_rdata);
         chk("o_rd_cnt", o_rd_cnt, m_rd_cnt);
         chk("o_wr_cnt", o_wr_cnt, m_wr_cnt);
         chk("o_addr_err", o_addr_err, m_err);
         if (i_end_proc) begin
            if (m_busy && cyc == m_commit_c) model_commit(1);
            m_busy = 0;
         end else if (!m_busy) begin
            if (e_rr || e_wr) begin
               m_op_wr    = e_wr;
               m_last_wr  = e_wr;
               m_addr     = e_wr ? wr_awaddr : rd_araddr;
               m_wdata    = wr_wdata;
               m_wstrb    = wr_wstrb;
               m_commit_c = cyc + i_delay_cnt + 1;
               m_resp_c   = m_commit_c + 1;
               m_busy     = 1;
               if (m_addr >= LIMIT) m_err = 1;
            end
         end else begin
            if (cyc == m_commit_c) model_commit(0);
            if (e_rv && rd_return_ready) begin m_rd_cnt++; m_busy = 0; end
            if (e_wv && wr_return_ready) begin m_wr_cnt++; m_busy = 0; end
         end
      end
      cyc++;
   end

   // Issue one request, measure cycles from accept to return valid, then hand it back.
   task automatic do_req(input bit wr, input logic [63:0] addr, input logic [511:0] data,
                         input logic [63:0] strb, input logic [63:0] d, input int hold,
                         output int acc_wait, output int lat, output logic [511:0] rdat);
      bit got;
      lat = -1; acc_wait = -1; rdat = '0; got = 0;
      i_delay_cnt = d;
      if (wr) begin wr_valid = 1; wr_awaddr = addr; wr_wdata = data; wr_wstrb = strb; end
      else begin rd_valid = 1; rd_araddr = addr; end
      for (int i = 1; i <= 50 && !got; i++) begin
         @(negedge afu_clk);
         got = wr ? wr_ready : rd_ready;
         if (got) acc_wait = i;
      end
      @(posedge afu_clk); #1;
      rd_valid = 0; wr_valid = 0;
      if (!got) begin fail_now("req_accept"); return; end
      got = 0;
      for (int i = 1; i <= 200 && !got; i++) begin
         @(negedge afu_clk);
         if (wr ? wr_return_valid : rd_return_valid) begin got = 1; lat = i; end
      end
      if (!got) begin fail_now("return_valid"); return; end
      repeat (hold) @(negedge afu_clk);
      @(posedge afu_clk); #1;
      if (wr) wr_return_ready = 1; else rd_return_ready = 1;
      @(negedge afu_clk);
      rdat = rd_rdata;
      @(posedge afu_clk); #1;
      wr_return_ready = 0; rd_return_ready = 0;
   endtask

   task automatic rand_line(output logic [511:0] v);
      for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom;
   endtask

   initial begin
      int aw, lat, g[$];
      logic [511:0] rd;
      logic [7:0] pb;
      bit got;

      for (int i = 0; i < 1024; i++) mem_m[i] = '0;

      // reset values, with both request valids high to show readies stay low
      rd_valid = 1; wr_valid = 1;
      #12;
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_rdata", rd_rdata, 0);
      chk("rst_rd_cnt", o_rd_cnt, 0);
      chk("rst_addr_err", o_addr_err, 0);
      rd_valid = 0; wr_valid = 0;
      @(posedge afu_clk); #1;
      afu_rstn = 1;
      model_reset();
      chk_en = 1;

      for (int i = 0; i < 8; i++) begin
         pb = 8'h10 + 8'(i);
         do_req(1, 64'(i) * 64, {64{pb}}, '1, 0, 0, aw, lat, rd);
      end

      do_req(1, 64'h40, {64{8'hA5}}, '1, 0, 0, aw, lat, rd);
      chk("t1_wr_latency", lat, 2);
      do_req(0, 64'h40, '0, '0, 0, 0, aw, lat, rd);
      chk("t1_rd_latency", lat, 2);
      chk("t1_rd_data", rd, {64{8'hA5}});
      chk("t1_wr_cnt", o_wr_cnt, 9);
      chk("t1_rd_cnt", o_rd_cnt, 1);

      do_req(1, 64'h0, '0, '1, 0, 0, aw, lat, rd);
      do_req(1, 64'h0, {64{8'hFF}}, 64'h0000_0000_0000_000F, 0, 0, aw, lat, rd);
      do_req(0, 64'h3, '0, '0, 0, 0, aw, lat, rd);
      chk("strobe_data", rd, {{60{8'h00}}, {4{8'hFF}}});

      do_req(0, 64'h40, '0, '0, 10, 5, aw, lat, rd);
      chk("delay10_latency", lat, 12);
      chk("delay10_data", rd, {64{8'hA5}});

      do_req(0, 64'h10000, '0, '0, 1, 0, aw, lat, rd);
      chk("oor_data", rd, 0);
      chk("oor_err", o_addr_err, 1);
      do_req(1, 64'hC0, {64{8'h13}}, '1, 0, 0, aw, lat, rd);
      chk("oor_err_sticky", o_addr_err, 1);

      // abort a D=20 write five cycles after accept
      i_delay_cnt = 20; wr_valid = 1; wr_awaddr = 64'h80; wr_wdata = {64{8'h11}}; wr_wstrb = '1;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin @(negedge afu_clk); got = wr_ready; end
      if (!got) fail_now("abort_accept");
      @(posedge afu_clk); #1; wr_valid = 0;
      repeat (4) @(posedge afu_clk);
      #1; i_end_proc = 1;
      @(posedge afu_clk); #1; i_end_proc = 0;
      do_req(0, 64'h80, '0, '0, 0, 0, aw, lat, rd);
      chk("abort_idle_next", aw, 1);
      chk("abort_old_data", rd, {64{8'h12}});
      chk("abort_wr_cnt", o_wr_cnt, 12);

      // 64-bit delay is not truncated; async reset lands mid-DELAY
      i_delay_cnt = 64'h8000_0000_0000_0005; rd_valid = 1; rd_araddr = 64'h40;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin @(negedge afu_clk); got = rd_ready; end
      if (!got) fail_now("hugeD_accept");
      @(posedge afu_clk); #1; rd_valid = 0;
      repeat (10) @(negedge afu_clk);
      #2;
      chk_en = 0; rd_valid = 1; wr_valid = 1; afu_rstn = 0;
      #1;
      chk("arst_rd_ready", rd_ready, 0);
      chk("arst_wr_ready", wr_ready, 0);
      chk("arst_rd_ret_valid", rd_return_valid, 0);
      chk("arst_wr_ret_valid", wr_return_valid, 0);
      chk("arst_rd_rdata", rd_rdata, 0);
      chk("arst_rd_cnt", o_rd_cnt, 0);
      chk("arst_wr_cnt", o_wr_cnt, 0);
      chk("arst_addr_err", o_addr_err, 0);

      // arbitration with both valids held from reset
      @(posedge afu_clk); #1;
      rd_araddr = 64'h40; wr_awaddr = 64'h100; wr_wdata = {64{8'h77}}; wr_wstrb = '1;
      i_delay_cnt = 0; rd_return_ready = 1; wr_return_ready = 1;
      @(posedge afu_clk); #1;
      afu_rstn = 1;
      model_reset();
      chk_en = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge afu_clk);
         chk("arb_exclusive", rd_ready && wr_ready, 0);
         if (rd_ready && rd_valid) g.push_back(0);
         if (wr_ready && wr_valid) g.push_back(1);
      end
      if (g.size() >= 3) begin
         chk("arb_grant0", g[0], 0);
         chk("arb_grant1", g[1], 1);
         chk("arb_grant2", g[2], 0);
      end else fail_now("arb_grants");
      @(posedge afu_clk); #1;
      rd_valid = 0; wr_valid = 0;
      repeat (4) @(posedge afu_clk);

      // randomized traffic with random backpressure and occasional aborts
      for (int i = 0; i < 3000; i++) begin
         @(posedge afu_clk); #1;
         rd_valid = ($urandom_range(0, 2) == 0);
         wr_valid = ($urandom_range(0, 2) == 0);
         rd_araddr = ($urandom_range(0, 15) == 0) ? (LIMIT + 64'($urandom_range(0, 4095)))
                   : 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
         wr_awaddr = ($urandom_range(0, 15) == 0) ? {32'($urandom) | 32'h1, 32'($urandom)}
                   : 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
         rand_line(wr_wdata);
         case ($urandom_range(0, 3))
            0: wr_wstrb = '0;
            1: wr_wstrb = '1;
            default: wr_wstrb = {32'($urandom), 32'($urandom)};
         endcase
         i_delay_cnt = 64'($urandom_range(0, 4));
         rd_return_ready = ($urandom_range(0, 2) != 0);
         wr_return_ready = ($urandom_range(0, 2) != 0);
         i_end_proc = ($urandom_range(0, 39) == 0);
      end
      @(posedge afu_clk); #1;
      rd_valid = 0; wr_valid = 0; i_end_proc = 0;
      rd_return_ready = 1; wr_return_ready = 1;
      repeat (20) @(posedge afu_clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
